// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake with wait
// states, and registers one instruction per cycle into the IF/ID pipeline register.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC_out,
  output logic        valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  logic        resp;
  logic [31:0] pc_inc;
  logic [31:0] br_target;

  assign br_target = branch_addr & ~32'd3;
  assign pc_inc    = pc_q + 32'd4;
  assign imem_req  = ((state_q == FETCH) || (state_q == DROP)) && rst;
  assign resp      = imem_req && imem_ready;

  assign imem_addr   = fetch_addr_q;
  assign Instruction = instr_q;
  assign PC_out      = pc_out_q;
  assign valid       = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;

    unique case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d     = br_target;
          instr_d  = 32'd0;
          pc_out_d = 32'd0;
          valid_d  = 1'b0;
          // Without a response the bus must keep the old address until it completes.
          if (resp) fetch_addr_d = br_target;
          else      state_d      = DROP;
        end else if (freeze) begin
          if (resp) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_inc;
            state_d      = HOLD;
          end
        end else if (resp) begin
          instr_d      = imem_rdata;
          pc_out_d     = pc_inc;
          valid_d      = 1'b1;
          pc_d         = pc_inc;
          fetch_addr_d = pc_inc;
        end else begin
          instr_d  = 32'd0;
          pc_out_d = 32'd0;
          valid_d  = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_d         = br_target;
          fetch_addr_d = br_target;
          instr_d      = 32'd0;
          pc_out_d     = 32'd0;
          valid_d      = 1'b0;
          state_d      = FETCH;
        end else if (!freeze) begin
          instr_d      = skid_instr_q;
          pc_out_d     = skid_pc_q;
          valid_d      = 1'b1;
          pc_d         = pc_inc;
          fetch_addr_d = pc_inc;
          state_d      = FETCH;
        end
      end

      DROP: begin
        instr_d  = 32'd0;
        pc_out_d = 32'd0;
        valid_d  = 1'b0;
        if (branch_taken) pc_d = br_target;
        // The stale word is discarded; the newest redirect target wins.
        if (resp) begin
          fetch_addr_d = branch_taken ? br_target : pc_q;
          state_d      = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      fetch_addr_q <= PC_RESET;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      instr_q      <= 32'd0;
      pc_out_q     <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory returns the word equal to its address; vectors give
// per-cycle inputs with expected bus outputs and expected IF/ID contents after the edge.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC_out;
  logic        valid;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .PC_out      (PC_out),
    .valid       (valid)
  );

  assign imem_rdata = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    bit          frz;
    bit          br;
    logic [31:0] baddr;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    bit          e_vld;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          vld;
  } ifid_t;

  vec_t  vec[$];
  ifid_t sb[$];

  function automatic vec_t mk(bit r, bit f, bit b, logic [31:0] ba, bit rd, bit er,
                              logic [31:0] ea, logic [31:0] ei, logic [31:0] ep, bit ev);
    vec_t v;
    v.do_rst = r; v.frz = f; v.br = b; v.baddr = ba; v.rdy = rd;
    v.e_req = er; v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_vld = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; asserts reset, checks cleared outputs, releases on next falling edge.
  task automatic do_reset();
    rst = 1'b0;
    freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; imem_ready = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_pcout", PC_out, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input vec_t v, input int idx);
    ifid_t e;
    ifid_t got;
    if (v.do_rst) do_reset();
    freeze = v.frz; branch_taken = v.br; branch_addr = v.baddr; imem_ready = v.rdy;
    #1;
    chk($sformatf("req[%0d]", idx), {31'd0, imem_req}, {31'd0, v.e_req});
    chk($sformatf("addr[%0d]", idx), imem_addr, v.e_addr);
    e.instr = v.e_instr; e.pc = v.e_pc; e.vld = v.e_vld;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", idx);
    end else begin
      got = sb.pop_front();
      chk($sformatf("instr[%0d]", idx), Instruction, got.instr);
      chk($sformatf("pcout[%0d]", idx), PC_out, got.pc);
      chk($sformatf("valid[%0d]", idx), {31'd0, valid}, {31'd0, got.vld});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; imem_ready = 1'b0;

    // Streaming at zero wait states
    vec.push_back(mk(1,0,0,0,1, 1,32'h0,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h4,  32'h4, 32'h8, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h8,  32'h8, 32'hC, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'hC,  32'hC, 32'h10,1));
    // Wait states at address 8
    vec.push_back(mk(1,0,0,0,1, 1,32'h0,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h4,  32'h4, 32'h8, 1));
    vec.push_back(mk(0,0,0,0,0, 1,32'h8,  32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,0, 1,32'h8,  32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'h8,  32'h8, 32'hC, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'hC,  32'hC, 32'h10,1));
    // Freeze coinciding with response at address 4, then branch out of HOLD
    vec.push_back(mk(1,0,0,0,1, 1,32'h0,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,1,0,0,1, 1,32'h4,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,1,0,0,1, 0,32'h4,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,1,0,0,1, 0,32'h4,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,0,0,0,1, 0,32'h4,  32'h4, 32'h8, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h8,  32'h8, 32'hC, 1));
    vec.push_back(mk(0,1,0,0,1, 1,32'hC,  32'h8, 32'hC, 1));
    vec.push_back(mk(0,1,1,32'h100,1, 0,32'hC, 32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'h100,32'h100,32'h104,1));
    // Branch while waiting at 12: DROP keeps the old address; low target bits ignored
    vec.push_back(mk(1,0,0,0,1, 1,32'h0,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h4,  32'h4, 32'h8, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h8,  32'h8, 32'hC, 1));
    vec.push_back(mk(0,0,0,0,0, 1,32'hC,  32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,1,32'h43,0, 1,32'hC, 32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,0, 1,32'hC,  32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'hC,  32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'h40, 32'h40,32'h44,1));
    // Repeated branches in DROP: the last target wins
    vec.push_back(mk(0,0,1,32'h200,0, 1,32'h44, 32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,1,32'h300,0, 1,32'h44, 32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'h44, 32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'h300,32'h300,32'h304,1));
    // Branch + freeze + response together, then PC wrap
    vec.push_back(mk(1,0,0,0,1, 1,32'h0,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,1,1,32'h80,1, 1,32'h4, 32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'h80, 32'h80,32'h84,1));
    vec.push_back(mk(0,0,1,32'hFFFF_FFFC,1, 1,32'h84, 32'h0, 32'h0, 0));
    vec.push_back(mk(0,0,0,0,1, 1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h0,  32'h0, 32'h4, 1));
    // Lead-in to a mid-wait reset at address 20
    vec.push_back(mk(1,0,0,0,1, 1,32'h0,  32'h0, 32'h4, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h4,  32'h4, 32'h8, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h8,  32'h8, 32'hC, 1));
    vec.push_back(mk(0,0,0,0,1, 1,32'hC,  32'hC, 32'h10,1));
    vec.push_back(mk(0,0,0,0,1, 1,32'h10, 32'h10,32'h14,1));
    vec.push_back(mk(0,1,0,0,0, 1,32'h14, 32'h10,32'h14,1));

    @(negedge clk);
    for (int i = 0; i < vec.size(); i++) step(vec[i], i);

    // Asynchronous reset pulsed while the request at 20 is pending
    rst = 1'b0;
    #1;
    chk("midrst_instr", Instruction, 32'd0);
    chk("midrst_pcout", PC_out, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    @(negedge clk);
    chk("midrst_req_hold", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    step(mk(0,0,0,0,1, 1,32'h0, 32'h0, 32'h4, 1), 1000);
    step(mk(0,0,0,0,1, 1,32'h4, 32'h4, 32'h8, 1), 1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
